// File: rtl/axis2axi_target_xy.sv
// Mesh target endpoint: accepts request packets from the router HOME port, replays each as one
// AXI4 master transaction on the local slave and packetizes the B/R response back to the requester.

package axis2axi_target_xy_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int DATA_WIDTH  = 32;
    localparam int ID_WIDTH    = 4;
    localparam int COORD_WIDTH = 4;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int FLIT_WIDTH  = 2 + 2*COORD_WIDTH + ID_WIDTH + 8 + 2 + ADDR_WIDTH;

    typedef struct packed {
        logic                  tvalid;
        logic [FLIT_WIDTH-1:0] tdata;
        logic                  tlast;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   awid;
        logic [ADDR_WIDTH-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [ID_WIDTH-1:0]   arid;
        logic [ADDR_WIDTH-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [ID_WIDTH-1:0]   bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [ID_WIDTH-1:0]   rid;
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } axi_miso_t;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        AW    = 4'd1,
        W     = 4'd2,
        B     = 4'd3,
        WRSP  = 4'd4,
        AR    = 4'd5,
        RHDR  = 4'd6,
        RDATA = 4'd7,
        DROP  = 4'd8
    } state_t;

endpackage

// Handshakes (AXIS and AXI alike): a beat transfers on a rising edge where VALID and READY are
// both high; VALID never waits on READY and, once raised, holds its payload until that edge.
module axis2axi_target_xy
    import axis2axi_target_xy_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESETn,
    input  axis_mosi_t s_axis_i,
    output axis_miso_t s_axis_o,
    input  axis_miso_t m_axis_i,
    output axis_mosi_t m_axis_o,
    input  axi_miso_t  m_axi_i,
    output axi_mosi_t  m_axi_o,
    output logic       proto_err_o,
    output state_t     dbg_state
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

    state_t                 state_q, state_d;
    state_t                 ret_q, ret_d;
    logic                   live_q;
    logic                   err_q;
    logic [COORD_WIDTH-1:0] y_q, x_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [7:0]             len_q;
    logic [1:0]             burst_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [1:0]             bresp_q;
    logic [7:0]             cnt_q;

    logic hdr_load, cnt_inc, b_load, err_set, last_beat;
    logic [1:0] hdr_kind;

    logic unused_ids;
    assign unused_ids = ^{m_axi_i.bid, m_axi_i.rid};

    assign hdr_kind  = s_axis_i.tdata[39:38];
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        hdr_load = 1'b0;
        cnt_inc  = 1'b0;
        b_load   = 1'b0;
        err_set  = 1'b0;
        s_axis_o = '0;
        m_axis_o = '0;
        m_axi_o  = '0;

        m_axi_o.awid    = id_q;
        m_axi_o.awaddr  = addr_q;
        m_axi_o.awlen   = len_q;
        m_axi_o.awsize  = AXI_SIZE;
        m_axi_o.awburst = burst_q;
        m_axi_o.arid    = id_q;
        m_axi_o.araddr  = addr_q;
        m_axi_o.arlen   = len_q;
        m_axi_o.arsize  = AXI_SIZE;
        m_axi_o.arburst = burst_q;
        m_axi_o.wdata   = s_axis_i.tdata[DATA_WIDTH-1:0];
        m_axi_o.wstrb   = s_axis_i.tdata[DATA_WIDTH+STRB_WIDTH-1:DATA_WIDTH];
        m_axi_o.wlast   = last_beat;

        case (state_q)
            IDLE: begin
                // live_q keeps TREADY low until the first edge after reset release
                s_axis_o.tready = live_q;
                if (live_q && s_axis_i.tvalid) begin
                    hdr_load = 1'b1;
                    case (hdr_kind)
                        2'b00: state_d = AW;
                        2'b01: begin
                            if (s_axis_i.tlast) begin
                                state_d = AR;
                            end else begin
                                err_set = 1'b1;
                                ret_d   = AR;
                                state_d = DROP;
                            end
                        end
                        default: begin
                            err_set = 1'b1;
                            if (!s_axis_i.tlast) begin
                                ret_d   = IDLE;
                                state_d = DROP;
                            end
                        end
                    endcase
                end
            end
            AW: begin
                m_axi_o.awvalid = 1'b1;
                if (m_axi_i.awready) state_d = W;
            end
            W: begin
                m_axi_o.wvalid  = s_axis_i.tvalid;
                s_axis_o.tready = m_axi_i.wready;
                if (s_axis_i.tvalid && m_axi_i.wready) begin
                    cnt_inc = 1'b1;
                    if (s_axis_i.tlast != last_beat) err_set = 1'b1;
                    if (last_beat) begin
                        if (s_axis_i.tlast) begin
                            state_d = B;
                        end else begin
                            ret_d   = B;
                            state_d = DROP;
                        end
                    end
                end
            end
            B: begin
                m_axi_o.bready = 1'b1;
                if (m_axi_i.bvalid) begin
                    b_load  = 1'b1;
                    state_d = WRSP;
                end
            end
            WRSP: begin
                m_axis_o.tvalid = 1'b1;
                m_axis_o.tdata  = {2'b10, y_q, x_q, id_q, bresp_q, 24'd0};
                m_axis_o.tlast  = 1'b1;
                if (m_axis_i.tready) state_d = IDLE;
            end
            AR: begin
                m_axi_o.arvalid = 1'b1;
                if (m_axi_i.arready) state_d = RHDR;
            end
            RHDR: begin
                m_axis_o.tvalid = 1'b1;
                m_axis_o.tdata  = {2'b11, y_q, x_q, id_q, 26'd0};
                if (m_axis_i.tready) state_d = RDATA;
            end
            RDATA: begin
                m_axis_o.tvalid = m_axi_i.rvalid;
                m_axis_o.tdata  = {{(FLIT_WIDTH-DATA_WIDTH-2){1'b0}}, m_axi_i.rresp, m_axi_i.rdata};
                m_axis_o.tlast  = m_axi_i.rlast;
                m_axi_o.rready  = m_axis_i.tready;
                if (m_axi_i.rvalid && m_axis_i.tready && m_axi_i.rlast) state_d = IDLE;
            end
            DROP: begin
                s_axis_o.tready = 1'b1;
                if (s_axis_i.tvalid && s_axis_i.tlast) state_d = ret_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            live_q  <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
            x_q     <= '0;
            id_q    <= '0;
            len_q   <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            bresp_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            live_q  <= 1'b1;
            if (err_set) err_q <= 1'b1;
            if (hdr_load) begin
                y_q     <= s_axis_i.tdata[37:34];
                x_q     <= s_axis_i.tdata[33:30];
                id_q    <= s_axis_i.tdata[29:26];
                len_q   <= s_axis_i.tdata[25:18];
                burst_q <= s_axis_i.tdata[17:16];
                addr_q  <= s_axis_i.tdata[15:0];
                cnt_q   <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (b_load) bresp_q <= m_axi_i.bresp;
        end
    end

    assign proto_err_o = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_axis2axi_target_xy.sv
// Directed bench for axis2axi_target_xy: drives request packets, models the local AXI slave and
// router sink, and scoreboards AW/W/AR beats and response flits against expected queues.
module tb_axis2axi_target_xy;
    import axis2axi_target_xy_pkg::*;

    logic       ACLK;
    logic       ARESETn;
    axis_mosi_t s_axis_i;
    axis_miso_t s_axis_o;
    axis_miso_t m_axis_i;
    axis_mosi_t m_axis_o;
    axi_miso_t  m_axi_i;
    axi_mosi_t  m_axi_o;
    logic       proto_err_o;
    state_t     dbg_state;

    axis2axi_target_xy dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .s_axis_i    (s_axis_i),
        .s_axis_o    (s_axis_o),
        .m_axis_i    (m_axis_i),
        .m_axis_o    (m_axis_o),
        .m_axi_i     (m_axi_i),
        .m_axi_o     (m_axi_o),
        .proto_err_o (proto_err_o),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;
    int duty   = 100;
    logic [1:0]  b_resp_cfg  = 2'b00;
    logic [1:0]  rd_resp_cfg = 2'b00;
    logic [31:0] rd_seed     = 32'd0;

    // scoreboard queues
    logic [29:0] exp_aw_q[$];
    logic [36:0] exp_w_q[$];
    logic [29:0] exp_ar_q[$];
    logic [40:0] exp_rsp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic rnd_ready();
        return (int'($urandom_range(99)) < duty);
    endfunction

    // monitor / scoreboard, sampled away from the active edge
    logic        w_last_fire = 1'b0, b_fire = 1'b0, ar_fire = 1'b0, r_fire = 1'b0;
    logic [7:0]  ar_len_s = 8'd0;
    logic        aw_stall = 1'b0, ar_stall = 1'b0, m_stall = 1'b0;
    logic [29:0] aw_hold, ar_hold;
    logic [40:0] m_hold;
    logic [29:0] aw_cur, ar_cur;
    logic [40:0] m_cur;

    assign aw_cur = {m_axi_o.awid, m_axi_o.awlen, m_axi_o.awburst, m_axi_o.awaddr};
    assign ar_cur = {m_axi_o.arid, m_axi_o.arlen, m_axi_o.arburst, m_axi_o.araddr};
    assign m_cur  = {m_axis_o.tlast, m_axis_o.tdata};

    always @(negedge ACLK) begin
        w_last_fire = 1'b0;
        b_fire      = 1'b0;
        ar_fire     = 1'b0;
        r_fire      = 1'b0;
        if (!ARESETn) begin
            aw_stall = 1'b0;
            ar_stall = 1'b0;
            m_stall  = 1'b0;
        end else begin
            if (aw_stall) check("aw_stable", 64'({m_axi_o.awvalid, aw_cur}), 64'({1'b1, aw_hold}));
            if (ar_stall) check("ar_stable", 64'({m_axi_o.arvalid, ar_cur}), 64'({1'b1, ar_hold}));
            if (m_stall)  check("rsp_stable", 64'({m_axis_o.tvalid, m_cur}), 64'({1'b1, m_hold}));
            if (m_axi_o.awvalid && m_axi_i.awready) begin
                check("aw_extra", 64'(exp_aw_q.size() != 0), 64'(1));
                check("aw_size", 64'(m_axi_o.awsize), 64'(2));
                if (exp_aw_q.size() != 0) check("aw_fields", 64'(aw_cur), 64'(exp_aw_q.pop_front()));
            end
            if (m_axi_o.wvalid && m_axi_i.wready) begin
                w_last_fire = m_axi_o.wlast;
                check("w_extra", 64'(exp_w_q.size() != 0), 64'(1));
                if (exp_w_q.size() != 0)
                    check("w_beat", 64'({m_axi_o.wlast, m_axi_o.wstrb, m_axi_o.wdata}), 64'(exp_w_q.pop_front()));
            end
            b_fire = m_axi_i.bvalid && m_axi_o.bready;
            if (m_axi_o.arvalid && m_axi_i.arready) begin
                ar_fire  = 1'b1;
                ar_len_s = m_axi_o.arlen;
                check("ar_extra", 64'(exp_ar_q.size() != 0), 64'(1));
                check("ar_size", 64'(m_axi_o.arsize), 64'(2));
                if (exp_ar_q.size() != 0) check("ar_fields", 64'(ar_cur), 64'(exp_ar_q.pop_front()));
            end
            r_fire = m_axi_i.rvalid && m_axi_o.rready;
            if (m_axis_o.tvalid && m_axis_i.tready) begin
                check("rsp_extra", 64'(exp_rsp_q.size() != 0), 64'(1));
                if (exp_rsp_q.size() != 0) check("rsp_flit", 64'(m_cur), 64'(exp_rsp_q.pop_front()));
            end
            aw_stall = m_axi_o.awvalid && !m_axi_i.awready;
            ar_stall = m_axi_o.arvalid && !m_axi_i.arready;
            m_stall  = m_axis_o.tvalid && !m_axis_i.tready;
            aw_hold  = aw_cur;
            ar_hold  = ar_cur;
            m_hold   = m_cur;
        end
    end

    // local AXI slave and router sink model
    int rd_len = 0;
    int rd_idx = 0;

    always @(posedge ACLK) begin
        #1;
        if (!ARESETn) begin
            m_axi_i  = '0;
            m_axis_i = '0;
            rd_len   = 0;
            rd_idx   = 0;
        end else begin
            m_axi_i.awready = rnd_ready();
            m_axi_i.wready  = rnd_ready();
            m_axi_i.arready = rnd_ready();
            m_axis_i.tready = rnd_ready();
            if (b_fire) m_axi_i.bvalid = 1'b0;
            if (w_last_fire) begin
                m_axi_i.bvalid = 1'b1;
                m_axi_i.bresp  = b_resp_cfg;
            end
            if (r_fire) rd_idx++;
            if (ar_fire) begin
                rd_len = int'(ar_len_s) + 1;
                rd_idx = 0;
            end
            m_axi_i.rvalid = (rd_idx < rd_len);
            m_axi_i.rdata  = rd_seed + 32'(rd_idx);
            m_axi_i.rlast  = (rd_idx == rd_len - 1);
            m_axi_i.rresp  = rd_resp_cfg;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_flit(input logic [39:0] data, input logic last);
        int   n   = 0;
        logic acc = 1'b0;
        if (duty < 100) repeat ($urandom_range(2)) tick();
        s_axis_i.tvalid = 1'b1;
        s_axis_i.tdata  = data;
        s_axis_i.tlast  = last;
        while (!acc && n < 1000) begin
            @(negedge ACLK);
            acc = s_axis_o.tready;
            tick();
            n++;
        end
        check("flit_accept", 64'(acc), 64'(1));
        s_axis_i.tvalid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] y, input logic [3:0] x, input logic [3:0] id,
                            input logic [7:0] len, input logic [15:0] addr, input int tlast_early);
        logic [31:0] d;
        logic [3:0]  st;
        exp_aw_q.push_back({id, len, 2'b01, addr});
        exp_rsp_q.push_back({1'b1, 2'b10, y, x, id, b_resp_cfg, 24'd0});
        send_flit({2'b00, y, x, id, len, 2'b01, addr}, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            d  = $urandom;
            st = 4'($urandom_range(15));
            exp_w_q.push_back({(i == int'(len)), st, d});
            send_flit({4'h0, st, d}, (i == int'(len)) || (i == tlast_early));
        end
    endtask

    task automatic do_read(input logic [3:0] y, input logic [3:0] x, input logic [3:0] id,
                           input logic [7:0] len, input logic [15:0] addr);
        exp_ar_q.push_back({id, len, 2'b01, addr});
        exp_rsp_q.push_back({1'b0, 2'b11, y, x, id, 26'd0});
        for (int i = 0; i <= int'(len); i++)
            exp_rsp_q.push_back({(i == int'(len)), 6'd0, rd_resp_cfg, rd_seed + 32'(i)});
        send_flit({2'b01, y, x, id, len, 2'b01, addr}, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size()) != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size()), 64'(0));
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_tready"}, 64'(s_axis_o.tready), 64'(0));
        check({tag, "_m_tvalid"}, 64'(m_axis_o.tvalid), 64'(0));
        check({tag, "_awvalid"},  64'(m_axi_o.awvalid), 64'(0));
        check({tag, "_wvalid"},   64'(m_axi_o.wvalid), 64'(0));
        check({tag, "_bready"},   64'(m_axi_o.bready), 64'(0));
        check({tag, "_arvalid"},  64'(m_axi_o.arvalid), 64'(0));
        check({tag, "_rready"},   64'(m_axi_o.rready), 64'(0));
        check({tag, "_proto_err"}, 64'(proto_err_o), 64'(0));
        check({tag, "_state"},    64'(dbg_state), 64'(IDLE));
    endtask

    task automatic pulse_reset(input string tag);
        ARESETn = 1'b0;
        #1;
        check_quiet(tag);
        s_axis_i.tvalid = 1'b0;
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_ar_q.delete();
        exp_rsp_q.delete();
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
    endtask

    // directed sequence
    initial begin
        ARESETn  = 1'b0;
        s_axis_i = '0;
        repeat (3) tick();
        check_quiet("reset");
        ARESETn = 1'b1;
        tick();
        check("idle_tready", 64'(s_axis_o.tready), 64'(1));

        // single-beat write
        exp_aw_q.push_back({4'd3, 8'd0, 2'b01, 16'h0040});
        exp_w_q.push_back({1'b1, 4'hF, 32'hDEADBEEF});
        exp_rsp_q.push_back({1'b1, 2'b10, 4'd2, 4'd1, 4'd3, 2'b00, 24'd0});
        send_flit({2'b00, 4'd2, 4'd1, 4'd3, 8'd0, 2'b01, 16'h0040}, 1'b0);
        send_flit({4'h0, 4'hF, 32'hDEADBEEF}, 1'b1);
        wait_drain("t1_drain");
        check("t1_err", 64'(proto_err_o), 64'(0));

        // four-beat read
        do_read(4'd1, 4'd2, 4'd5, 8'd3, 16'h0100);
        wait_drain("t2_drain");
        check("t2_err", 64'(proto_err_o), 64'(0));

        // non-zero BRESP and the 256-beat boundary
        b_resp_cfg = 2'b10;
        do_write(4'd3, 4'd3, 4'd7, 8'd2, 16'h0200, -1);
        wait_drain("bresp_drain");
        b_resp_cfg = 2'b00;
        do_write(4'd0, 4'd0, 4'd1, 8'd255, 16'h1000, -1);
        wait_drain("len255_drain");

        // random backpressure on every ready
        duty        = 30;
        rd_resp_cfg = 2'b01;
        rd_seed     = 32'h1000_0000;
        for (int k = 0; k < 6; k++) begin
            b_resp_cfg = 2'($urandom_range(3));
            if (k % 2 == 0)
                do_write(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                         8'($urandom_range(7)), 16'($urandom), -1);
            else
                do_read(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                        8'($urandom_range(7)), 16'($urandom));
            wait_drain("bp_drain");
        end
        duty = 100;
        check("bp_err", 64'(proto_err_o), 64'(0));

        // early TLAST on a two-beat write
        b_resp_cfg = 2'b00;
        do_write(4'd1, 4'd1, 4'd2, 8'd1, 16'h0300, 0);
        wait_drain("t5_drain");
        check("t5_err", 64'(proto_err_o), 64'(1));

        pulse_reset("rst2");

        // response-kind packets are dropped
        send_flit({2'b11, 4'd1, 4'd1, 4'd4, 26'd0}, 1'b0);
        send_flit(40'h12_3456_789A, 1'b0);
        send_flit(40'h00_CAFE_F00D, 1'b1);
        repeat (10) tick();
        check("t4_err", 64'(proto_err_o), 64'(1));
        check("t4_idle", 64'(dbg_state), 64'(IDLE));
        send_flit({2'b10, 4'd2, 4'd2, 4'd4, 26'd0}, 1'b1);
        repeat (5) tick();
        check("t4b_tready", 64'(s_axis_o.tready), 64'(1));
        do_write(4'd5, 4'd6, 4'd8, 8'd2, 16'h0600, -1);
        wait_drain("t4_recover_drain");

        pulse_reset("rst3");

        // reset in the middle of a write
        exp_aw_q.push_back({4'd6, 8'd3, 2'b01, 16'h0400});
        exp_w_q.push_back({1'b0, 4'h3, 32'h1111_2222});
        send_flit({2'b00, 4'd4, 4'd4, 4'd6, 8'd3, 2'b01, 16'h0400}, 1'b0);
        send_flit({4'h0, 4'h3, 32'h1111_2222}, 1'b0);
        s_axis_i.tvalid = 1'b1;
        s_axis_i.tdata  = {4'h0, 4'hF, 32'h3333_4444};
        s_axis_i.tlast  = 1'b0;
        #1;
        check("t6_pre_wvalid", 64'(m_axi_o.wvalid), 64'(1));
        pulse_reset("t6_rst");
        do_write(4'd2, 4'd2, 4'd9, 8'd1, 16'h0500, -1);
        wait_drain("t6_drain");
        check("t6_err", 64'(proto_err_o), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
